itof_pipe: RTL and testbench
============================

Name: itof_pipe

Overview:
- Pipelined signed 32-bit integer to IEEE-754 single-precision converter for the FPU.
- Performs the inverse of the float-to-int path, using the same rounding rule: round half away from zero on the magnitude.
- Three register stages, with a valid/ready handshake on input and output.
- Sits between the FPU operand mux and the FPU result writeback.

Parameters:
- None. Widths are fixed at 32-bit integer in and binary32 out.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept an operand this cycle
- in_data  in  32  two's-complement signed integer
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  32  binary32 result: {sign, exp[7:0], frac[22:0]}

Behaviour:
- Reset:
  - One clock; reset is asynchronous, active-low (rstn).
  - While rstn=0, all stage valid flags are 0, so out_valid=0.
  - out_data=0 and all stage data registers are 0.
  - Asserting reset mid-operation discards in-flight operands; there is no partial output.
- Advance enable: en = ~out_valid | out_ready. All three stages shift together when en=1 and hold when en=0.
- in_ready = en. This is a combinational path from out_ready and is allowed.
- An input transfer occurs when in_valid & in_ready. Otherwise a bubble (valid=0) enters stage 1.
- Latency: exactly 3 clk edges from transfer to out_valid when out_ready is held high. Throughput is 1 per cycle.
- While out_valid & ~out_ready, out_data and out_valid are held stable with no glitch or change.
- Stage 1:
  - sign = in_data[31].
  - mag = sign ? (~in_data + 1) : in_data, held as a 32-bit unsigned value. 0x80000000 gives mag 0x80000000.
  - zero = (in_data == 0).
- Stage 2:
  - lz = leading-zero count of mag (0..31; don't-care when zero).
  - norm = mag << lz, so norm[31]=1 unless zero.
  - exp_pre = 158 - lz, 8-bit.
- Stage 3:
  - frac_raw = norm[30:8]; guard = norm[7]; the remaining bits norm[6:0] do not affect the result.
  - rounding: up = guard (half away from zero).
  - {carry, frac} = {1'b0, frac_raw} + up, 24-bit.
  - On carry: frac = 0 and exp = exp_pre + 1. Otherwise exp = exp_pre.
  - out_data = zero ? 32'h0000_0000 : {sign, exp, frac}. Zero input always gives +0.
- Results are always exact or correctly rounded. No overflow is possible (max exponent 158), and there are no NaN, Inf or denormal outputs.

Decomposition:
- Shared fpu package holds:
  - FP_EXP_BIAS = 127
  - ITOF_EXP_TOP = 158 (bias + 31)
  - widths FP_EXP_W = 8, FP_FRAC_W = 23
  - the binary32 field slice constants shared with the float-to-int block
- One sub-module: lzc32. It is a combinational 32-bit leading-zero counter with 5-bit output and a valid/all-zero flag, instantiated in stage 2. It is reusable by the future fadd normaliser.

Test Plan:
- Basic values, out_ready=1, back-to-back:
  - 1 -> 0x3F800000
  - -1 -> 0xBF800000
  - 0 -> 0x00000000
  - 3 -> 0x40400000
  - Each result appears exactly 3 cycles after its transfer, in order.
- Rounding:
  - 0x01000001 (2^24+1) -> 0x4B800001
  - 0x01000002 -> 0x4B800001
  - 0x01000003 -> 0x4B800002
  - -16777217 -> 0xCB800001
- Carry and extremes:
  - 0x7FFFFFFF -> 0x4F000000 (mantissa carry, exponent becomes 158)
  - 0x80000000 -> 0xCF000000
  - 0x00FFFFFF -> 0x4B7FFFFF
- Backpressure:
  - Issue 5 operands with out_ready=0 from cycle 2.
  - in_ready drops once out_valid=1 and out_ready=0; out_data is stable for the whole stall.
  - Release out_ready: all 5 results drain in order with none lost or duplicated.
- Bubbles: alternate in_valid 1/0 with random ints. Compare against a reference model (C cast with round-half-away) over 10k random values plus all powers of two and ±(2^k±1).
- Reset mid-flight: with 3 operands in the pipe, pulse rstn low asynchronously between edges.
  - out_valid=0 immediately and no stale result appears after release.
  - The first new operand emerges 3 cycles after its transfer.

Source files
------------

// File: rtl/itof_pipe_pkg.sv
// Shared binary32 constants for the FPU integer/float conversion paths.
package itof_pipe_pkg;

  localparam int unsigned FP_EXP_W     = 8;
  localparam int unsigned FP_FRAC_W    = 23;
  localparam int unsigned FP_EXP_BIAS  = 127;
  // Exponent of a value whose leading one sits at bit 31 of the magnitude.
  localparam int unsigned ITOF_EXP_TOP = FP_EXP_BIAS + 31;

  // binary32 field slices.
  localparam int unsigned FP_SIGN_BIT  = 31;
  localparam int unsigned FP_EXP_MSB   = 30;
  localparam int unsigned FP_EXP_LSB   = 23;
  localparam int unsigned FP_FRAC_MSB  = 22;
  localparam int unsigned FP_FRAC_LSB  = 0;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; valid=0 flags an all-zero input.
module lzc32 (
  input  logic [31:0] data,
  output logic [4:0]  cnt,
  output logic        valid
);

  // Scan upwards so the highest set bit has the final word.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) begin
        cnt = 5'(31 - i);
      end
    end
  end

  assign valid = |data;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to binary32 converter, round half away from zero.
module itof_pipe
  import itof_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic en;

  // Stage 1: sign / magnitude
  logic        v1_q, sign1_q;
  logic [31:0] mag1_q, mag1_d;

  // Stage 2: normalised mantissa (frac + guard) and pre-round exponent
  logic                v2_q, sign2_q, zero2_q;
  logic [FP_FRAC_W:0]  norm2_q, norm2_d;
  logic [FP_EXP_W-1:0] exp2_q, exp2_d;
  logic [4:0]          lz;
  logic                lz_valid;

  // Stage 3: rounded result
  logic                v3_q;
  logic [31:0]         res3_q, res3_d;
  logic [FP_FRAC_W:0]  rnd_sum;
  logic [FP_EXP_W-1:0] exp3;

  assign en       = ~v3_q | out_ready;
  assign in_ready = en;

  assign mag1_d = in_data[31] ? (~in_data + 32'd1) : in_data;

  lzc32 u_lzc (
    .data  (mag1_q),
    .cnt   (lz),
    .valid (lz_valid)
  );

  // Keep norm[30:7]: 23 fraction bits plus the guard bit; norm[31] is the hidden one.
  assign norm2_d = (FP_FRAC_W + 1)'((mag1_q << lz) >> 7);
  assign exp2_d  = FP_EXP_W'(ITOF_EXP_TOP) - {3'b000, lz};

  always_comb begin
    rnd_sum = {1'b0, norm2_q[FP_FRAC_W:1]} + (FP_FRAC_W + 1)'(norm2_q[0]);
    // A carry out leaves the fraction bits at zero, so only the exponent needs bumping.
    exp3    = exp2_q + FP_EXP_W'(rnd_sum[FP_FRAC_W]);
    res3_d  = '0;
    if (!zero2_q) begin
      res3_d[FP_SIGN_BIT]             = sign2_q;
      res3_d[FP_EXP_MSB:FP_EXP_LSB]   = exp3;
      res3_d[FP_FRAC_MSB:FP_FRAC_LSB] = rnd_sum[FP_FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      norm2_q <= '0;
      exp2_q  <= '0;
      v3_q    <= 1'b0;
      res3_q  <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      sign1_q <= in_data[31];
      mag1_q  <= mag1_d;
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      zero2_q <= ~lz_valid;
      norm2_q <= norm2_d;
      exp2_q  <= exp2_d;
      v3_q    <= v2_q;
      res3_q  <= res3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = res3_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: transfers push model results, outputs pop and record them.
module tb_itof_pipe;

  logic        clk, rstn, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;

  itof_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] got;
    logic [31:0] exp;
    int          lat;
    bit          extra;
  } res_t;

  exp_t exp_q[$];
  res_t res_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, required test completion");
    $fatal(1, "watchdog");
  end

  // Reference: locate the MSB, then truncate to 24 bits and add the first dropped bit.
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    logic        s;
    logic [31:0] m, man;
    int          p, e;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (32'd0 - x) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      man = m << (23 - p);
    end else begin
      man = m >> (p - 23);
      if (m[p-24]) man = man + 32'd1;
      if (man[24]) begin
        man = man >> 1;
        e++;
      end
    end
    return {s, 8'(e), man[22:0]};
  endfunction

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back('{exp: ref_itof(in_data), cyc: cyc});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          res_q.push_back('{got: out_data, exp: 32'd0, lat: 0, extra: 1'b1});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          res_q.push_back('{got: out_data, exp: e.exp, lat: cyc - e.cyc, extra: 1'b0});
        end
      end
    end
  end

  // Drive one operand, holding it until accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, output bit timed_out);
    bit acc = 0;
    timed_out = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    timed_out = !acc;
  endtask

  task automatic flush(output bit timed_out);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    timed_out = (exp_q.size() != 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b want=0", out_valid); end
    total++;
    if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data: got=%h want=0", out_data); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b want=1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends a table of operands back to back and checks values against spelled-out constants.
  task automatic test_table(input string name, input logic [31:0] ops[], input logic [31:0] want[]);
    bit to, any_to = 0;
    res_t r;
    foreach (ops[i]) begin
      send(ops[i], to);
      any_to |= to;
    end
    flush(to);
    any_to |= to;
    total++;
    if (any_to || res_q.size() != ops.size()) begin
      bad++;
      $display("FAIL %s_count: got=%0d results want=%0d timeout=%0d", name, res_q.size(), ops.size(), any_to);
    end
    for (int i = 0; res_q.size() != 0; i++) begin
      r = res_q.pop_front();
      total++;
      if (r.extra || i >= want.size() || r.got !== want[i] || r.lat != 3) begin
        bad++;
        $display("FAIL %s[%0d]: got=%h lat=%0d extra=%0d want=%h lat=3", name, i, r.got, r.lat,
                 r.extra, (i < want.size()) ? want[i] : 32'hx);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ops[5]  = '{32'd5, 32'hFFFF_FFF9, 32'd1000, 32'h0100_0003, 32'd0};
    logic [31:0] want[5] = '{32'h40A0_0000, 32'hC0E0_0000, 32'h447A_0000, 32'h4B80_0002, 32'd0};
    logic [31:0] held = '0;
    bit          stalled = 0;
    int          idx = 0;
    res_t        r;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 2 && c < 14);
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? ops[idx] : 32'd0;
      @(negedge clk);
      if (c >= 3 && c < 14) begin
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_stall c=%0d: got valid=%b ready=%b want valid=1 ready=0", c, out_valid,
                   in_ready);
        end
        if (!stalled) begin
          held    = out_data;
          stalled = 1;
        end else begin
          total++;
          if (out_data !== held) begin
            bad++;
            $display("FAIL bp_hold c=%0d: got=%h want=%h", c, out_data, held);
          end
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (idx != 5 || res_q.size() != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got sent=%0d results=%0d pending=%0d want 5/5/0", idx, res_q.size(),
               exp_q.size());
    end
    for (int i = 0; res_q.size() != 0; i++) begin
      r = res_q.pop_front();
      total++;
      if (r.extra || i >= 5 || r.got !== want[i % 5]) begin
        bad++;
        $display("FAIL bp_drain[%0d]: got=%h extra=%0d want=%h", i, r.got, r.extra, want[i % 5]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] vals[$];
    bit          to, any_to = 0;
    int          n;
    res_t        r;
    for (int k = 0; k < 32; k++) begin
      vals.push_back(32'd1 << k);
      vals.push_back(32'd0 - (32'd1 << k));
      vals.push_back((32'd1 << k) + 32'd1);
      vals.push_back((32'd1 << k) - 32'd1);
      vals.push_back(32'd0 - ((32'd1 << k) + 32'd1));
      vals.push_back(32'd0 - ((32'd1 << k) - 32'd1));
    end
    for (int i = 0; i < 10000; i++) vals.push_back($urandom());
    n = vals.size();
    foreach (vals[i]) begin
      send(vals[i], to);
      any_to |= to;
      @(posedge clk);
      #1;
    end
    flush(to);
    any_to |= to;
    total++;
    if (any_to || res_q.size() != n) begin
      bad++;
      $display("FAIL bubble_count: got=%0d want=%0d timeout=%0d", res_q.size(), n, any_to);
    end
    for (int i = 0; res_q.size() != 0; i++) begin
      r = res_q.pop_front();
      total++;
      if (r.extra || r.got !== r.exp || r.lat != 3) begin
        bad++;
        $display("FAIL bubble[%0d] in=%h: got=%h lat=%0d extra=%0d want=%h lat=3", i,
                 (i < n) ? vals[i] : 32'hx, r.got, r.lat, r.extra, r.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   to;
    res_t r;
    send(32'd7, to);
    send(32'd8, to);
    send(32'd9, to);
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b data=%h want valid=0 data=0", out_valid, out_data);
    end
    #1;
    rstn = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (res_q.size() != 0) begin
      bad++;
      $display("FAIL mid_stale: got %0d results after reset want 0", res_q.size());
      res_q.delete();
    end
    send(32'd6, to);
    flush(to);
    total++;
    if (to || res_q.size() != 1) begin
      bad++;
      $display("FAIL mid_count: got=%0d want=1 timeout=%0d", res_q.size(), to);
    end
    while (res_q.size() != 0) begin
      r = res_q.pop_front();
      total++;
      if (r.extra || r.got !== 32'h40C0_0000 || r.lat != 3) begin
        bad++;
        $display("FAIL mid_first: got=%h lat=%0d extra=%0d want=40c00000 lat=3", r.got, r.lat,
                 r.extra);
      end
    end
  endtask

  initial begin
    test_reset();
    test_table("basic", '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd3},
               '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4040_0000});
    test_table("round", '{32'h0100_0001, 32'h0100_0002, 32'h0100_0003, 32'hFEFF_FFFF},
               '{32'h4B80_0001, 32'h4B80_0001, 32'h4B80_0002, 32'hCB80_0001});
    test_table("extreme", '{32'h7FFF_FFFF, 32'h8000_0000, 32'h00FF_FFFF},
               '{32'h4F00_0000, 32'hCF00_0000, 32'h4B7F_FFFF});
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
